// File: rtl/uart_cmd_engine.sv
// Byte-oriented command engine behind a UART: register writes/reads,
// one-shot strobes, and an ACK/NAK/data response queue toward the transmitter.
module uart_cmd_engine #(
  parameter int NUM_REGS       = 8,
  parameter int REG_BYTES      = 2,
  parameter int NUM_STROBES    = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      rx_data_i,
  input  logic                            rx_valid_i,
  output logic [7:0]                      tx_data_o,
  output logic                            tx_valid_o,
  input  logic                            tx_ready_i,
  output logic [NUM_REGS*REG_BYTES*8-1:0] regs_o,
  output logic [NUM_STROBES-1:0]          strobe_o,
  output logic                            busy_o,
  output logic                            drop_o
);

  localparam int RW = REG_BYTES * 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    MASK,
    RESP
  } state_t;

  state_t state, state_n;

  logic                   is_rd;
  logic [7:0]             addr;
  logic [1:0]             bcnt;
  logic [RW-1:0]          wbuf;
  logic [RW-1:0]          qbuf;
  logic [2:0]             qlen;
  logic [TW-1:0]          tcnt;
  logic [NUM_REGS*RW-1:0] regs_q;

  logic          rx_ok, addr_ok, in_frame, tmo, xfer, last;
  logic [RW-1:0] new_word, rd_val, q_val;
  logic [2:0]    q_cnt;
  logic          q_load, we, stb;

  function automatic logic [RW-1:0] code(input logic [7:0] c);
    code = '0;
    code[RW-1 -: 8] = c;
  endfunction

  assign rx_ok    = {1'b0, rx_data_i} < 9'(NUM_REGS);
  assign addr_ok  = {1'b0, addr} < 9'(NUM_REGS);
  assign in_frame = (state == ADDR) || (state == DATA) || (state == MASK);
  assign tmo      = in_frame && !rx_valid_i && (tcnt == TW'(TIMEOUT_CYCLES));
  assign xfer     = (state == RESP) && tx_ready_i;
  assign last     = bcnt == 2'(REG_BYTES - 1);
  assign new_word = RW'({wbuf, rx_data_i});

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (rx_data_i == 8'(k)) rd_val = regs_q[k*RW +: RW];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    q_load  = 1'b0;
    q_val   = '0;
    q_cnt   = 3'd1;
    we      = 1'b0;
    stb     = 1'b0;
    if (tmo) begin
      state_n = RESP;
      q_load  = 1'b1;
      q_val   = code(8'h15);
    end else begin
      unique case (state)
        IDLE: if (rx_valid_i) begin
          unique case (rx_data_i)
            8'h77, 8'h72: state_n = ADDR;
            8'h73:        state_n = MASK;
            default: begin
              state_n = RESP;
              q_load  = 1'b1;
              q_val   = code(8'h15);
            end
          endcase
        end
        ADDR: if (rx_valid_i) begin
          if (is_rd) begin
            state_n = RESP;
            q_load  = 1'b1;
            if (rx_ok) begin
              q_val = rd_val;
              q_cnt = 3'(REG_BYTES);
            end else begin
              q_val = code(8'h15);
            end
          end else begin
            state_n = DATA;
          end
        end
        DATA: if (rx_valid_i && last) begin
          state_n = RESP;
          q_load  = 1'b1;
          we      = addr_ok;
          q_val   = addr_ok ? code(8'h06) : code(8'h15);
        end
        MASK: if (rx_valid_i) begin
          state_n = RESP;
          q_load  = 1'b1;
          stb     = 1'b1;
          q_val   = code(8'h06);
        end
        RESP: if (xfer && qlen == 3'd1) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_rd    <= 1'b0;
      addr     <= '0;
      bcnt     <= '0;
      wbuf     <= '0;
      qbuf     <= '0;
      qlen     <= '0;
      tcnt     <= '0;
      regs_q   <= '0;
      strobe_o <= '0;
      drop_o   <= 1'b0;
    end else begin
      tcnt     <= (rx_valid_i || !in_frame) ? '0 : tcnt + TW'(1);
      drop_o   <= rx_valid_i && (state == RESP);
      strobe_o <= stb ? rx_data_i[NUM_STROBES-1:0] : '0;
      if (state == IDLE && rx_valid_i) is_rd <= (rx_data_i == 8'h72);
      if (state == ADDR && rx_valid_i) begin
        addr <= rx_data_i;
        bcnt <= '0;
      end
      if (state == DATA && rx_valid_i) begin
        wbuf <= new_word;
        bcnt <= bcnt + 2'(1);
      end
      if (we)
        for (int k = 0; k < NUM_REGS; k++)
          if (addr == 8'(k)) regs_q[k*RW +: RW] <= new_word;
      // Queue is a left-shifting buffer; the top byte is always the one on offer
      if (q_load) begin
        qbuf <= q_val;
        qlen <= q_cnt;
      end else if (xfer) begin
        qbuf <= RW'({qbuf, 8'h00});
        qlen <= qlen - 3'd1;
      end
    end
  end

  assign regs_o     = regs_q;
  assign tx_valid_o = (state == RESP);
  assign tx_data_o  = tx_valid_o ? qbuf[RW-1 -: 8] : 8'h00;
  assign busy_o     = (state != IDLE);

endmodule

// File: doc/uart_cmd_engine.md
UART_CMD_ENGINE -- requirements
Module: uart_cmd_engine

Interface
REQ-001 Parameter NUM_REGS, default 8, number of host-writable registers (range 1..256).
REQ-002 Parameter REG_BYTES, default 2, bytes per register (range 1..4), transferred MSB first.
REQ-003 Parameter NUM_STROBES, default 8, number of one-cycle strobe outputs (range 1..8).
REQ-004 Parameter TIMEOUT_CYCLES, default 50000, allowed idle clocks between bytes of one frame.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 rx_data_i  input  8  received byte from UART receiver.
REQ-008 rx_valid_i  input  1  one-cycle pulse qualifying rx_data_i.
REQ-009 tx_data_o  output  8  byte to UART transmitter.
REQ-010 tx_valid_o  output  1  tx_data_o valid; transfer occurs on a cycle with tx_valid_o and tx_ready_i both high.
REQ-011 tx_ready_i  input  1  transmitter can accept a byte.
REQ-012 regs_o  output  NUM_REGS*REG_BYTES*8  flat register file; register k occupies bits [(k+1)*REG_BYTES*8-1 : k*REG_BYTES*8].
REQ-013 strobe_o  output  NUM_STROBES  one-cycle command strobes.
REQ-014 busy_o  output  1  high whenever FSM is not IDLE.
REQ-015 drop_o  output  1  one-cycle pulse when an rx byte is discarded.

Function
REQ-016 FSM states: IDLE, ADDR, DATA, MASK, RESP; any other encoding returns to IDLE on the next cycle.
REQ-017 IDLE + rx byte 0x77 'w' -> ADDR (write); 0x72 'r' -> ADDR (read); 0x73 's' -> MASK; any other byte -> RESP with queue = {0x15 NAK}.
REQ-018 ADDR, write: latch address byte, byte counter = 0, -> DATA.
REQ-019 ADDR, read: address < NUM_REGS -> RESP with queue = the REG_BYTES bytes of that register, MSB first; otherwise queue = {0x15}.
REQ-020 DATA: shift each byte into a REG_BYTES-wide buffer; after the REG_BYTES-th byte, address < NUM_REGS -> register updated, visible on regs_o in the cycle after that byte's rx_valid_i, queue = {0x06 ACK}; otherwise no register changes and queue = {0x15}; -> RESP.
REQ-021 MASK: strobe_o = rx_data_i[NUM_STROBES-1:0], high for exactly the cycle after that byte's rx_valid_i; queue = {0x06}; -> RESP.
REQ-022 strobe_o is zero in every cycle except the one given in REQ-021.
REQ-023 RESP: tx_valid_o high and tx_data_o held stable until the transfer; next queued byte is presented in the cycle after each transfer; after the last transfer -> IDLE.
REQ-024 Timeout: counter clears on each rx_valid_i and counts while in ADDR, DATA or MASK; when it reaches TIMEOUT_CYCLES, the frame is aborted, no register is written, no strobe fires, queue = {0x15}, -> RESP.
REQ-025 Any rx_valid_i while in RESP: byte discarded, drop_o pulses for one cycle, state unaffected.
REQ-026 Address comparison uses the full 8-bit address byte; for NUM_REGS = 256 all addresses are valid.
REQ-027 A read of a register returns the value from the most recent completed write, including a write completed in the immediately preceding frame.

Reset
REQ-028 While rst is high: state = IDLE, regs_o = 0, strobe_o = 0, tx_valid_o = 0, tx_data_o = 0x00, busy_o = 0, drop_o = 0, timeout counter = 0.
REQ-029 rst asserted mid-frame or mid-response discards the partial frame and the pending queue; no transfer occurs on the cycle after reset is released.

Verification (NUM_REGS=8, REG_BYTES=2, NUM_STROBES=8, TIMEOUT_CYCLES=100)
REQ-030 rx 77 03 12 34 -> regs_o[63:48]=0x1234 one cycle after 0x34; tx 0x06; other registers unchanged.
REQ-031 Continue from REQ-030: rx 72 03 with tx_ready_i held low 20 cycles -> tx_data_o=0x12 held stable throughout; then tx 0x12, 0x34; busy_o low after the last transfer.
REQ-032 rx 77 09 AA BB -> no regs_o change, tx 0x15; rx 72 08 -> tx 0x15 only; rx 0x41 -> tx 0x15.
REQ-033 rx 73 A5 -> strobe_o=0xA5 for exactly one cycle, tx 0x06; extra rx byte sent during the response -> drop_o pulses, byte ignored.
REQ-034 rx 77 01 56, then no byte for 100 cycles -> tx 0x15, register 1 unchanged, FSM back in IDLE; a subsequent rx 72 01 returns 0x00 0x00.
REQ-035 rst pulsed after rx 77 02 11 -> regs_o=0, no tx; the next rx 77 02 22 33 writes 0x2233 normally and tx 0x06.
